// File: rtl/dmem_line_ctrl.sv
// Line-oriented data memory for the data-cache miss path: one 256-bit line per request,
// fixed LATENCY, one-cycle ack. Optional protocol checker under `DMEM_PROTOCOL_CHECK_EN.
module dmem_line_ctrl #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

    state_e             state_q;
    logic [7:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [255:0]       wdata_q;
    logic [255:0]       data_q;
    logic               ack_q;
    logic [255:0]       mem_q [DEPTH];
    logic               access_d;

    // The access happens on the edge where the countdown reaches 1 (edge LATENCY-1).
    assign access_d = (state_q == BUSY) && (cnt_q == 8'd1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        idx_q   <= addr_i[5 +: IDX_W];
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= 8'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (access_d) begin
                        ack_q   <= 1'b1;
                        data_q  <= wr_q ? wdata_q : mem_q[idx_q];
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array is not reset; the rst_i term keeps an aborted write from ever committing.
    always_ff @(posedge clk_i) begin
        if (rst_i && access_d && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;

    // Offset and alias bits are intentionally ignored by the line decode.
    logic unused_addr;
    assign unused_addr = ^{addr_i[4:0], addr_i[31:5+IDX_W]};

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic [31:0] addr_q;
    logic        err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && enable_i) begin
                addr_q <= addr_i;
                if (addr_i[4:0] != 5'd0) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == BUSY &&
                (!enable_i || addr_i != addr_q || write_i != wr_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
